data_memory_block: RTL and testbench
====================================

Name: data_memory_block

Overview:
- Block-granular data memory that responds to the data cache's memory-side interface.
- Services one 32-bit block read or write per request, with a fixed multi-cycle latency signalled by busywait.
- Sits between the data cache's miss/write-back FSM and nothing further downstream; it is the backing store for the data address space.
- Storage is 64 blocks × 32 bits (256 bytes); byte offset 0 of a block occupies bits [7:0].

Parameters:
- ADDR_WIDTH, 6, block address width; depth = 2^ADDR_WIDTH blocks.
- DATA_WIDTH, 32, block width in bits.
- LATENCY, 5, clock cycles busywait stays high per accepted request; legal range is 2..15.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset (sampled on posedge clk).
- read  input  1  block read request from the cache (cache mem_read).
- write  input  1  block write-back request from the cache (cache mem_write).
- address  input  ADDR_WIDTH  block address {tag,index} (cache mem_address).
- writedata  input  DATA_WIDTH  block to write (cache mem_writedata).
- readdata  output  DATA_WIDTH  registered block returned by a read (cache mem_readdata).
- busywait  output  1  high while a request is in progress (cache mem_busywait).

Behaviour:
- Reset values: state IDLE, counter 0, readdata 0.
  - busywait = 0 once reset deasserts, unless a request is pending.
  - Memory array is NOT cleared by reset.
- FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - A request is valid when exactly one of read/write is high.
  - busywait is combinational: busywait = 1 in IDLE when a valid request is present, so the cache stalls in the same cycle it raises the request.
  - On posedge with a valid request: latch op, address and writedata; counter ← 1; go to BUSY.
  - read and write both high: illegal. No latch, busywait stays 0, remain in IDLE.
- BUSY:
  - busywait = 1.
  - Counter increments each posedge.
  - On the posedge where counter == LATENCY−1, commit the operation and go to DONE:
    - read: readdata ← mem[latched address].
    - write: mem[latched address] ← latched writedata; readdata unchanged.
- DONE:
  - Lasts exactly 1 cycle; busywait = 0.
  - read/write are ignored in this state, because the cache deasserts them only on this edge, so this prevents re-triggering.
  - Next posedge: go to IDLE.
- Latency: cycle 0 is the first cycle with a request in IDLE.
  - busywait is high in cycles 0..LATENCY−1 and low in cycle LATENCY.
  - readdata is valid from cycle LATENCY and held until the next completed read.
- Latched request: address, writedata and read/write changing after acceptance have no effect; the latched operation completes even if the request drops.
- Back-to-back: a request present in the cycle after DONE (now IDLE) is accepted normally, so the minimum spacing between accepts is LATENCY+1 cycles.
- Reset mid-operation: the operation is aborted and a pending write is not committed. State returns to IDLE, readdata ← 0, busywait low in the next cycle.
- Reset has priority over a request in the same cycle.

Test Plan:
- Reset then idle: reset high for 2 cycles, read=write=0 → busywait=0, readdata=0x00000000.
- Write then read, LATENCY=5:
  - Write 0xDEADBEEF to address 0x2A: busywait high for exactly 5 cycles, then low for 1.
  - Read of 0x2A: busywait high for 5 cycles; readdata=0xDEADBEEF in cycle 5.
- Cache-style handshake: drive read/write high until the first posedge at which busywait=0, then drop them → exactly one operation is performed and no second busywait pulse appears.
- Latched inputs:
  - Start a write of 0x11223344 to 0x05, then change address to 0x06 and writedata to 0 in cycle 1.
  - mem[0x05]=0x11223344 and mem[0x06] unchanged, both confirmed by reads.
- Reset mid-write:
  - Preload mem[0x10]=0xAAAAAAAA, start a write of 0x55555555 to 0x10, assert reset in cycle 3.
  - Required: busywait=0 next cycle; a later read of 0x10 returns 0xAAAAAAAA.
- Illegal request: read=write=1 for 4 cycles → busywait stays 0, state stays IDLE, memory and readdata unchanged.

Source files
------------

// File: rtl/data_memory_block_if.sv
// Memory-side bus between the data cache and the block data memory.
// The cache drives requests as master; the memory answers as slave.
interface data_memory_block_if #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  read;
  logic                  write;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] writedata;
  logic [DATA_WIDTH-1:0] readdata;
  logic                  busywait;

  modport master (
    output read, write, address, writedata,
    input  readdata, busywait
  );

  modport slave (
    input  read, write, address, writedata,
    output readdata, busywait
  );
endinterface

// File: rtl/data_memory_block.sv
// Block-granular backing store for the data cache: one block read or write per
// request, completed after a fixed LATENCY-cycle busywait window.
module data_memory_block #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LATENCY    = 5   // legal range 2..15 (4-bit counter)
) (
  input logic              clk,
  input logic              reset,
  data_memory_block_if.slave bus
);

  localparam int unsigned Depth   = 1 << ADDR_WIDTH;
  localparam logic [3:0]  LastCnt = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  op_write_q, op_write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  commit;
  logic                  busywait;
  logic                  req_valid;

  logic [DATA_WIDTH-1:0] mem [Depth];

  // Simultaneous read and write is treated as no request at all.
  assign req_valid = bus.read ^ bus.write;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_write_d = op_write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    commit     = 1'b0;
    busywait   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          busywait   = 1'b1;
          op_write_d = bus.write;
          addr_d     = bus.address;
          wdata_d    = bus.writedata;
          cnt_d      = 4'd1;
          state_d    = StBusy;
        end
      end
      StBusy: begin
        busywait = 1'b1;
        cnt_d    = cnt_q + 4'd1;
        if (cnt_q == LastCnt) begin
          commit  = 1'b1;
          state_d = StDone;
          if (!op_write_q) begin
            rdata_d = mem[addr_q];
          end
        end
      end
      // Requests are still asserted here by the cache; ignore them.
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_write_q <= op_write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
    end
  end

  // Array is deliberately not reset; a reset-aborted write never commits.
  always_ff @(posedge clk) begin
    if (!reset && commit && op_write_q) begin
      mem[addr_q] <= wdata_q;
    end
  end

  assign bus.busywait = busywait;
  assign bus.readdata = rdata_q;

endmodule

// File: tb/tb_data_memory_block.sv
// Self-checking bench for data_memory_block: cache-style handshakes with a
// read-data scoreboard, latching, reset abort and illegal-request cases.
module tb_data_memory_block;

  localparam int unsigned AW      = 6;
  localparam int unsigned DW      = 32;
  localparam int unsigned LATENCY = 5;

  logic clk = 1'b0;
  logic reset;

  data_memory_block_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  data_memory_block #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .LATENCY   (LATENCY)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] model_mem [64];
  logic [31:0] exp_q [$];
  logic [31:0] last_rd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Cache-style request: hold until the first posedge with busywait low, then drop.
  task automatic run_op(input bit is_wr, input logic [AW-1:0] addr, input logic [31:0] data,
                        input bit mutate, input string tag);
    int          cycles;
    bit          done;
    logic [31:0] exp;
    cycles = 0;
    done   = 1'b0;
    @(posedge clk); #1;
    bus.read      = ~is_wr;
    bus.write     = is_wr;
    bus.address   = addr;
    bus.writedata = data;
    if (is_wr) model_mem[addr] = data;
    else exp_q.push_back(model_mem[addr]);
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bus.busywait) cycles++;
      else done = 1'b1;
      if (mutate && i == 0) begin
        @(posedge clk); #1;
        bus.address   = 6'h06;
        bus.writedata = 32'h0;
      end
    end
    check_eq({tag, "_done"}, {31'b0, done}, 32'd1);
    check_eq({tag, "_busy_cycles"}, cycles, LATENCY);
    if (done && !is_wr) begin
      if (exp_q.size() == 0) begin
        check_eq({tag, "_sb_empty"}, {31'b0, done}, 32'd0);
      end else begin
        exp = exp_q.pop_front();
        check_eq({tag, "_readdata"}, bus.readdata, exp);
        last_rd = exp;
      end
    end
    @(posedge clk); #1;
    bus.read  = 1'b0;
    bus.write = 1'b0;
    @(negedge clk);
    check_eq({tag, "_no_repulse"}, {31'b0, bus.busywait}, 32'd0);
  endtask

  initial begin
    reset         = 1'b1;
    bus.read      = 1'b0;
    bus.write     = 1'b0;
    bus.address   = '0;
    bus.writedata = '0;
    last_rd       = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst_busywait", {31'b0, bus.busywait}, 32'd0);
    check_eq("rst_readdata", bus.readdata, 32'h0);

    run_op(1'b1, 6'h2A, 32'hDEADBEEF, 1'b0, "wr_2a");
    run_op(1'b0, 6'h2A, 32'h0, 1'b0, "rd_2a");

    // Address/data changed after acceptance must not affect the write.
    run_op(1'b1, 6'h06, 32'h0BADF00D, 1'b0, "wr_06");
    run_op(1'b1, 6'h05, 32'h11223344, 1'b1, "wr_05_latched");
    run_op(1'b0, 6'h05, 32'h0, 1'b0, "rd_05");
    run_op(1'b0, 6'h06, 32'h0, 1'b0, "rd_06");

    run_op(1'b1, 6'h00, 32'h01020304, 1'b0, "wr_00");
    run_op(1'b1, 6'h3F, 32'hF0E0D0C0, 1'b0, "wr_3f");
    run_op(1'b0, 6'h3F, 32'h0, 1'b0, "rd_3f");
    run_op(1'b0, 6'h00, 32'h0, 1'b0, "rd_00");

    // Reset in cycle 3 of a write aborts it.
    run_op(1'b1, 6'h10, 32'hAAAAAAAA, 1'b0, "wr_10_pre");
    @(posedge clk); #1;
    bus.write     = 1'b1;
    bus.address   = 6'h10;
    bus.writedata = 32'h55555555;
    repeat (3) @(posedge clk);
    #1;
    reset     = 1'b1;
    bus.write = 1'b0;
    @(negedge clk);
    check_eq("abort_busy_before", {31'b0, bus.busywait}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_eq("abort_busywait", {31'b0, bus.busywait}, 32'd0);
    check_eq("abort_readdata", bus.readdata, 32'h0);
    last_rd = 32'h0;
    run_op(1'b0, 6'h10, 32'h0, 1'b0, "rd_10_after_abort");

    // Illegal read+write for 4 cycles.
    @(posedge clk); #1;
    bus.read      = 1'b1;
    bus.write     = 1'b1;
    bus.address   = 6'h2A;
    bus.writedata = 32'h12345678;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq($sformatf("illegal_busy_%0d", i), {31'b0, bus.busywait}, 32'd0);
      check_eq($sformatf("illegal_rdata_%0d", i), bus.readdata, last_rd);
      @(posedge clk); #1;
    end
    bus.read  = 1'b0;
    bus.write = 1'b0;
    run_op(1'b0, 6'h2A, 32'h0, 1'b0, "rd_2a_after_illegal");

    check_eq("sb_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
